led_stepper: RTL and testbench
==============================

Name: led_stepper

Overview:
- Parametrised successor to the button-driven LED advancer on the board top level; implemented in fabric, no soft processor involved.
- Synchronises and debounces the push-button, then advances an N-bit LED pattern once per debounced press.
- Offers four selectable patterns and an optional free-running auto-advance timer.
- Outputs drive board LEDs directly; one-cycle step pulse exported for other logic.

Parameters:
- LED_COUNT, 4, number of LEDs / pattern width (>=1).
- DEBOUNCE_CYCLES, 50000, consecutive stable synchronised cycles needed to accept a button level change (>=1).
- AUTO_PERIOD, 25000000, cycles between auto-advance ticks (>=2).
- BTN_ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed.

Ports:
- clk_clk  input  1  system clock; all state on rising edge.
- reset_reset  input  1  synchronous, active-high reset.
- btn_external_connection_export  input  1  raw asynchronous push-button.
- mode_export  input  2  pattern select: 0 one-hot rotate, 1 binary count, 2 ping-pong, 3 hold.
- auto_en_export  input  1  1 = auto-advance timer enabled.
- leds_external_connection_export  output  LED_COUNT  registered LED pattern.
- step_pulse_export  output  1  registered, high one cycle per applied advance.

Behaviour:
- One clock (clk_clk); reset_reset synchronous, active-high; all outputs registered.
- Reset values:
  - leds = 1 (bit0 set).
  - step_pulse = 0.
  - sync flops = not-pressed; debounced state = released; debounce counter = 0; auto timer = 0.
  - ping-pong direction = up; mode_q = 0.
- Synchroniser: 2-flop on raw button, polarity normalised by BTN_ACTIVE_LOW to btn_s (1 = pressed).
- Debounce:
  - Counter increments while btn_s != btn_db; clears whenever btn_s == btn_db.
  - On reaching DEBOUNCE_CYCLES-1 with btn_s still different, btn_db <= btn_s and counter clears.
  - Pulses shorter than DEBOUNCE_CYCLES cycles are ignored.
- Press event: btn_db rising 0->1 generates an internal one-cycle press. Releases generate nothing. Holding the button yields exactly one press.
- Auto timer:
  - Counts 0..AUTO_PERIOD-1 while auto_en=1 and wraps; tick asserted on wrap.
  - auto_en=0 clears the timer to 0 with no tick.
- Advance = press OR tick. Coincident press and tick give a single advance.
- Mode change:
  - mode_q registers mode_export each cycle.
  - If mode_export != mode_q, the pattern reloads that cycle, step_pulse stays 0, and any coincident advance is dropped.
  - Reload values: mode 0 -> 1; mode 1 -> 0; mode 2 -> 1 with dir=up; mode 3 -> unchanged.
- Advance rules, applied on the cycle after the press/tick is generated:
  - Mode 0: rotate left; MSB wraps to bit0.
  - Mode 1: leds+1 modulo 2^LED_COUNT; all-ones wraps to 0.
  - Mode 2: one-hot moves up while dir=up. On reaching MSB, dir flips to down, and the next step moves down. On reaching bit0, dir flips to up.
    - Sequence for 4: 0001,0010,0100,1000,0100,0010,0001,0010...
    - LED_COUNT=1: stays 1.
  - Mode 3: no pattern change, but step_pulse still asserts.
- step_pulse_export is high in the same cycle the updated leds value first appears.
- Latency: btn_s stable-pressed for DEBOUNCE_CYCLES cycles -> btn_db set -> press next cycle -> leds/step_pulse updated following cycle.
  - Total from raw pin change to leds update: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- Reset mid-operation (mid-debounce, mid-timer, mid-ping-pong) returns every register to its reset value on the next edge. A held button after reset release must re-debounce and produces one press.
- No illegal states: any non-one-hot leds value in modes 0/2 (reachable only via a mode switch from 1 then back) is replaced by reload, since a mode switch always reloads.

Test Plan (LED_COUNT=4, DEBOUNCE_CYCLES=4, AUTO_PERIOD=8, BTN_ACTIVE_LOW=1):
- Reset, mode 0, press (btn=0) held 20 cycles -> exactly one step_pulse, leds 0001->0010, 7 cycles after pin falls. Four further presses -> 0100,1000,0001,0010.
- Bounce: btn toggles 0/1 every 2 cycles for 30 cycles, then stays 1 -> no step_pulse, leds unchanged. Glitch of exactly 3 cycles low ignored; exactly 4 cycles low accepted.
- Mode 1, auto_en=1, no button -> a tick every 8 cycles; leds 0000,0001,...,1111,0000 wraps after 16 ticks; step_pulse count = 16.
- Mode 2 with 7 presses -> 0010,0100,1000,0100,0010,0001,0010.
- Press accepted in the same cycle tick fires -> single step_pulse, single increment. Mode change 1->0 coincident with a tick -> leds=0001, no step_pulse that cycle.
- Reset asserted mid-debounce while in mode 2 with dir=down -> leds=0001, step_pulse=0. Held button after release -> one press, leds 0010 (dir up).

Source files
------------

// File: rtl/led_stepper.sv
// Button-driven LED pattern stepper: synchronises and debounces a push-button,
// then advances one of four LED patterns per press or per auto-advance tick.
module led_stepper #(
  parameter int LED_COUNT       = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int AUTO_PERIOD     = 25000000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic                 btn_external_connection_export,
  input  logic [1:0]           mode_export,
  input  logic                 auto_en_export,
  output logic [LED_COUNT-1:0] leds_external_connection_export,
  output logic                 step_pulse_export
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AUTO_W = $clog2(AUTO_PERIOD);
  localparam logic [DB_W-1:0]      DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AUTO_W-1:0]    AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);
  localparam logic                 IDLE_LVL  = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [LED_COUNT-1:0] LED_ONE   = LED_COUNT'(1);
  localparam logic [LED_COUNT-1:0] LED_MSB   = LED_ONE << (LED_COUNT - 1);

  typedef enum logic [1:0] {
    MODE_ROTATE   = 2'd0,
    MODE_COUNT    = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_HOLD     = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic                 sync_a, sync_b, btn_s;
  logic [DB_W-1:0]      db_cnt;
  logic                 btn_db, btn_db_q, press;
  logic [AUTO_W-1:0]    auto_cnt;
  logic                 tick, advance;
  mode_e                mode_in, mode_q;
  dir_e                 dir_q, dir_next;
  logic [LED_COUNT-1:0] leds_q, leds_next;
  logic                 step_q, step_next;

  // Synchroniser flops idle at the raw "not pressed" level.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync_a <= IDLE_LVL;
      sync_b <= IDLE_LVL;
    end else begin
      sync_a <= btn_external_connection_export;
      sync_b <= sync_a;
    end
  end

  assign btn_s = BTN_ACTIVE_LOW ? ~sync_b : sync_b;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      db_cnt   <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_s == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press = btn_db & ~btn_db_q;

  // Free-running timer; disabling it parks the count at zero.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      auto_cnt <= '0;
    end else if (!auto_en_export || auto_cnt == AUTO_LAST) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + 1'b1;
    end
  end

  assign tick    = auto_en_export && (auto_cnt == AUTO_LAST);
  assign advance = press | tick;
  assign mode_in = mode_e'(mode_export);

  // A mode switch reloads the pattern and swallows any coincident advance.
  always_comb begin
    leds_next = leds_q;
    dir_next  = dir_q;
    step_next = 1'b0;
    if (mode_in != mode_q) begin
      case (mode_in)
        MODE_ROTATE:   leds_next = LED_ONE;
        MODE_COUNT:    leds_next = '0;
        MODE_PINGPONG: begin
          leds_next = LED_ONE;
          dir_next  = DIR_UP;
        end
        default:       leds_next = leds_q;
      endcase
    end else if (advance) begin
      step_next = 1'b1;
      case (mode_in)
        MODE_ROTATE:   leds_next = (leds_q << 1) | (leds_q >> (LED_COUNT - 1));
        MODE_COUNT:    leds_next = leds_q + 1'b1;
        MODE_PINGPONG: begin
          if (LED_COUNT == 1) begin
            leds_next = LED_ONE;
          end else if (dir_q == DIR_UP) begin
            leds_next = leds_q << 1;
            if (leds_next == LED_MSB) dir_next = DIR_DOWN;
          end else begin
            leds_next = leds_q >> 1;
            if (leds_next == LED_ONE) dir_next = DIR_UP;
          end
        end
        default:       leds_next = leds_q;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      leds_q <= LED_ONE;
      dir_q  <= DIR_UP;
      mode_q <= MODE_ROTATE;
      step_q <= 1'b0;
    end else begin
      leds_q <= leds_next;
      dir_q  <= dir_next;
      mode_q <= mode_in;
      step_q <= step_next;
    end
  end

  assign leds_external_connection_export = leds_q;
  assign step_pulse_export               = step_q;

endmodule

// File: tb/tb_led_stepper.sv
// Scoreboard bench for led_stepper: a behavioural model predicts every step pulse
// (cycle and LED value) and a monitor checks each pulse the DUT presents.
module tb_led_stepper;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int AP = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         btn = 1'b1;
  logic         auto_en = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [N-1:0] leds;
  logic         step;

  led_stepper #(
    .LED_COUNT(N),
    .DEBOUNCE_CYCLES(DB),
    .AUTO_PERIOD(AP),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_clk(clk),
    .reset_reset(reset),
    .btn_external_connection_export(btn),
    .mode_export(mode),
    .auto_en_export(auto_en),
    .leds_external_connection_export(leds),
    .step_pulse_export(step)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [N-1:0] leds;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   pulse_count = 0;
  int   last_pulse_cyc = -1;

  // Reference model state: pattern kept as abstract indices, debounce as a sample window.
  bit           pipe[$];
  bit           win[$];
  bit           db_m, press_pend, s_m, flip_m, tick_m, adv_m;
  int           en_run, p0, cnt1, ph, pos;
  logic [1:0]   last_mode;
  logic [N-1:0] exp_leds;
  exp_t         e_push, e_pop;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      pipe.delete();
      pipe.push_back(1'b0);
      pipe.push_back(1'b0);
      win.delete();
      for (int i = 0; i < DB; i++) win.push_back(1'b0);
      db_m = 0; press_pend = 0; en_run = 0;
      p0 = 0; cnt1 = 0; ph = 0;
      last_mode = 2'd0;
      exp_leds = N'(1);
    end else begin
      tick_m = 0;
      if (auto_en) begin
        en_run++;
        tick_m = (en_run % AP) == 0;
      end else begin
        en_run = 0;
      end
      adv_m = press_pend || tick_m;
      if (mode != last_mode) begin
        case (mode)
          2'd0: begin p0 = 0; exp_leds = N'(1); end
          2'd1: begin cnt1 = 0; exp_leds = '0; end
          2'd2: begin ph = 0; exp_leds = N'(1); end
          default: ;
        endcase
      end else if (adv_m) begin
        case (mode)
          2'd0: begin p0 = (p0 + 1) % N; exp_leds = N'(1 << p0); end
          2'd1: begin cnt1 = (cnt1 + 1) % (1 << N); exp_leds = N'(cnt1); end
          2'd2: begin
            if (N > 1) begin
              ph = (ph + 1) % (2 * N - 2);
              pos = (ph < N) ? ph : (2 * N - 2 - ph);
              exp_leds = N'(1 << pos);
            end
          end
          default: ;
        endcase
        e_push.cyc = cyc;
        e_push.leds = exp_leds;
        sb.push_back(e_push);
      end
      last_mode = mode;
      s_m = pipe.pop_front();
      pipe.push_back(btn == 1'b0);
      void'(win.pop_front());
      win.push_back(s_m);
      flip_m = 1;
      foreach (win[i]) if (win[i] == db_m) flip_m = 0;
      press_pend = 0;
      if (flip_m) begin
        db_m = ~db_m;
        press_pend = db_m;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: retires predictions that never showed up, then checks each presented pulse.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      tests++;
      fails++;
      $display("[TB] FAIL missing_pulse: got no pulse at cycle %0d, expected leds %0d",
               sb[0].cyc, sb[0].leds);
      void'(sb.pop_front());
    end
    if (step === 1'b1) begin
      pulse_count++;
      last_pulse_cyc = cyc;
      if (sb.size() == 0 || sb[0].cyc != cyc) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_pulse: got pulse at cycle %0d with leds %0d, expected none",
                 cyc, leds);
      end else begin
        e_pop = sb.pop_front();
        checkOutput("pulse_leds", int'(leds), int'(e_pop.leds));
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int low, input int high);
    btn = 1'b0;
    waitCycles(low);
    btn = 1'b1;
    waitCycles(high);
  endtask

  int start, p;
  int seq0[4] = '{2, 4, 8, 1};
  int seq2[7] = '{2, 4, 8, 4, 2, 1, 2};

  initial begin
    reset = 1'b1;
    waitCycles(3);
    reset = 1'b0;
    checkOutput("reset_leds", int'(leds), 1);
    checkOutput("reset_pulse", int'(step), 0);

    // Mode 0: one long press, then four more.
    start = cyc;
    p = pulse_count;
    btn = 1'b0;
    waitCycles(20);
    checkOutput("press_latency", last_pulse_cyc, start + 7);
    checkOutput("hold_one_pulse", pulse_count - p, 1);
    checkOutput("first_rotate", int'(leds), 2);
    btn = 1'b1;
    waitCycles(8);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8, 8);
      checkOutput("rotate_seq", int'(leds), seq0[(i + 1) % 4] == 1 ? 1 : seq0[(i + 1) % 4]);
    end

    // Bounce and glitches.
    p = pulse_count;
    for (int i = 0; i < 8; i++) begin
      btn = 1'b0; waitCycles(2);
      btn = 1'b1; waitCycles(2);
    end
    waitCycles(10);
    checkOutput("bounce_no_pulse", pulse_count - p, 0);
    checkOutput("bounce_leds", int'(leds), 2);
    applyStimulus(3, 10);
    checkOutput("glitch3_ignored", pulse_count - p, 0);
    applyStimulus(4, 10);
    checkOutput("glitch4_accepted", pulse_count - p, 1);
    checkOutput("glitch4_leds", int'(leds), 4);

    // Mode 1 auto-advance through a full wrap.
    p = pulse_count;
    mode = 2'd1;
    auto_en = 1'b1;
    waitCycles(16 * AP);
    auto_en = 1'b0;
    checkOutput("auto_tick_count", pulse_count - p, 16);
    checkOutput("count_wrapped", int'(leds), 0);

    // Mode 2 ping-pong.
    mode = 2'd2;
    waitCycles(2);
    checkOutput("pingpong_reload", int'(leds), 1);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(8, 8);
      checkOutput("pingpong_seq", int'(leds), seq2[i]);
    end

    // Reset in the middle of a debounce while moving down.
    for (int i = 0; i < 3; i++) applyStimulus(8, 8);
    checkOutput("pingpong_down", int'(leds), 4);
    btn = 1'b0;
    waitCycles(3);
    reset = 1'b1;
    waitCycles(1);
    reset = 1'b0;
    checkOutput("midreset_leds", int'(leds), 1);
    checkOutput("midreset_pulse", int'(step), 0);
    p = pulse_count;
    waitCycles(20);
    checkOutput("held_after_reset_pulses", pulse_count - p, 1);
    checkOutput("held_after_reset_leds", int'(leds), 2);
    btn = 1'b1;
    waitCycles(8);

    // Press lands on a tick; then a mode switch lands on a tick.
    p = pulse_count;
    mode = 2'd1;
    auto_en = 1'b1;
    waitCycles(9);
    btn = 1'b0;
    waitCycles(7);
    checkOutput("coincident_pulses", pulse_count - p, 2);
    checkOutput("coincident_leds", int'(leds), 2);
    waitCycles(1);
    btn = 1'b1;
    waitCycles(6);
    mode = 2'd0;
    waitCycles(1);
    checkOutput("modechg_leds", int'(leds), 1);
    checkOutput("modechg_no_pulse", int'(step), 0);
    checkOutput("modechg_pulse_count", pulse_count - p, 2);
    auto_en = 1'b0;
    waitCycles(10);

    // Randomised traffic against the model.
    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 9))
        0, 1: begin
          mode = 2'($urandom_range(0, 3));
          waitCycles(int'($urandom_range(1, 4)));
        end
        2: begin
          auto_en = ~auto_en;
          waitCycles(int'($urandom_range(1, 4)));
        end
        3, 4, 5, 6: applyStimulus(int'($urandom_range(1, 9)), int'($urandom_range(1, 9)));
        7: waitCycles(int'($urandom_range(1, 12)));
        8: begin
          if ($urandom_range(0, 3) == 0) begin
            reset = 1'b1;
            waitCycles(int'($urandom_range(1, 2)));
            reset = 1'b0;
          end
          waitCycles(1);
        end
        default: begin
          repeat ($urandom_range(2, 6)) begin
            btn = 1'($urandom_range(0, 1));
            waitCycles(int'($urandom_range(1, 3)));
          end
          btn = 1'b1;
          waitCycles(1);
        end
      endcase
      checkOutput("rand_leds", int'(leds), int'(exp_leds));
    end

    btn = 1'b1;
    auto_en = 1'b0;
    waitCycles(20);
    checkOutput("scoreboard_empty", sb.size(), 0);
    checkOutput("final_leds", int'(leds), int'(exp_leds));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
